// File: rtl/ysyx_22040750_bus_pkg.sv
// ysyx_22040750_bus_pkg: shared state and owner encodings for the memory arbiter
package ysyx_22040750_bus_pkg;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;
    typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_t;
endpackage

// File: rtl/ysyx_22040750_prio_sel.sv
// ysyx_22040750_prio_sel: MEM-first grant with a starvation counter that lets IF through
module ysyx_22040750_prio_sel #(
    parameter int STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_if_valid,
    input  logic i_mem_valid,
    output logic o_grant_if,
    output logic o_grant_mem
);
    localparam int CW = $clog2(STARVE_MAX + 2);
    logic [CW-1:0] r_cnt;
    logic          w_starved;
    assign w_starved   = r_cnt == CW'(STARVE_MAX);
    assign o_grant_if  = i_en & i_if_valid & (~i_mem_valid | w_starved);
    assign o_grant_mem = i_en & i_mem_valid & ~o_grant_if;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (o_grant_if || (o_grant_mem && !i_if_valid))
            r_cnt <= '0;
        else if (o_grant_mem && !w_starved)
            r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/ysyx_22040750_mem_arbiter.sv
// ysyx_22040750_mem_arbiter: arbitrates IF and MEM requesters onto one single-outstanding bus
module ysyx_22040750_mem_arbiter
    import ysyx_22040750_bus_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic        I_sys_clk,
    input  logic        I_rst_n,
    input  logic        I_if_req_valid,
    input  logic [31:0] I_if_addr,
    output logic        O_if_req_ready,
    output logic        O_if_resp_valid,
    output logic [63:0] O_if_rdata,
    input  logic        I_mem_req_valid,
    input  logic [31:0] I_mem_addr,
    input  logic        I_mem_wen,
    input  logic [63:0] I_mem_wdata,
    input  logic [7:0]  I_mem_wstrb,
    output logic        O_mem_req_ready,
    output logic        O_mem_resp_valid,
    output logic [63:0] O_mem_rdata,
    output logic        O_bus_req_valid,
    input  logic        I_bus_req_ready,
    output logic [31:0] O_bus_addr,
    output logic        O_bus_wen,
    output logic [63:0] O_bus_wdata,
    output logic [7:0]  O_bus_wstrb,
    input  logic        I_bus_resp_valid,
    input  logic [63:0] I_bus_rdata,
    output logic        O_busy
);
    state_t      r_state, w_next;
    owner_t      r_owner;
    logic        w_grant_if, w_grant_mem;
    logic [31:0] r_addr;
    logic        r_wen;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic        r_if_resp_valid, r_mem_resp_valid;
    logic [63:0] r_if_rdata, r_mem_rdata;

    // gating with reset keeps req_ready low while reset is held
    ysyx_22040750_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_prio_sel (
        .i_clk       (I_sys_clk),
        .i_rst_n     (I_rst_n),
        .i_en        ((r_state == S_IDLE) & I_rst_n),
        .i_if_valid  (I_if_req_valid),
        .i_mem_valid (I_mem_req_valid),
        .o_grant_if  (w_grant_if),
        .o_grant_mem (w_grant_mem)
    );

    always_comb begin
        w_next = r_state;
        w_next = (r_state == S_IDLE) ? ((w_grant_if | w_grant_mem) ? S_REQ : S_IDLE)
               : (r_state == S_REQ)  ? (I_bus_req_ready ? S_WAIT : S_REQ)
               : (r_state == S_WAIT) ? (I_bus_resp_valid ? S_IDLE : S_WAIT)
               : S_IDLE;
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_owner          <= OWN_IF;
            r_addr           <= '0;
            r_wen            <= 1'b0;
            r_wdata          <= '0;
            r_wstrb          <= '0;
            r_if_resp_valid  <= 1'b0;
            r_mem_resp_valid <= 1'b0;
            r_if_rdata       <= '0;
            r_mem_rdata      <= '0;
        end else begin
            r_if_resp_valid  <= 1'b0;
            r_mem_resp_valid <= 1'b0;
            if (w_grant_mem) begin
                r_owner <= OWN_MEM;
                r_addr  <= I_mem_addr;
                r_wen   <= I_mem_wen;
                r_wdata <= I_mem_wdata;
                r_wstrb <= I_mem_wstrb;
            end else if (w_grant_if) begin
                r_owner <= OWN_IF;
                r_addr  <= I_if_addr;
                r_wen   <= 1'b0;
                r_wdata <= '0;
                r_wstrb <= '0;
            end
            if (r_state == S_WAIT && I_bus_resp_valid) begin
                if (r_owner == OWN_MEM) begin
                    r_mem_resp_valid <= 1'b1;
                    r_mem_rdata      <= r_wen ? '0 : I_bus_rdata;
                end else begin
                    r_if_resp_valid <= 1'b1;
                    r_if_rdata      <= I_bus_rdata;
                end
            end
        end
    end

    assign O_if_req_ready   = w_grant_if;
    assign O_mem_req_ready  = w_grant_mem;
    assign O_if_resp_valid  = r_if_resp_valid;
    assign O_if_rdata       = r_if_rdata;
    assign O_mem_resp_valid = r_mem_resp_valid;
    assign O_mem_rdata      = r_mem_rdata;
    assign O_bus_req_valid  = r_state == S_REQ;
    assign O_bus_addr       = r_addr;
    assign O_bus_wen        = r_wen;
    assign O_bus_wdata      = r_wdata;
    assign O_bus_wstrb      = r_wstrb;
    assign O_busy           = r_state != S_IDLE;
endmodule

// File: tb/tb_ysyx_22040750_mem_arbiter.sv
// tb_ysyx_22040750_mem_arbiter: directed scoreboard bench for the IF/MEM bus arbiter
module tb_ysyx_22040750_mem_arbiter;
    logic        I_sys_clk, I_rst_n;
    logic        I_if_req_valid;
    logic [31:0] I_if_addr;
    logic        O_if_req_ready, O_if_resp_valid;
    logic [63:0] O_if_rdata;
    logic        I_mem_req_valid;
    logic [31:0] I_mem_addr;
    logic        I_mem_wen;
    logic [63:0] I_mem_wdata;
    logic [7:0]  I_mem_wstrb;
    logic        O_mem_req_ready, O_mem_resp_valid;
    logic [63:0] O_mem_rdata;
    logic        O_bus_req_valid, I_bus_req_ready;
    logic [31:0] O_bus_addr;
    logic        O_bus_wen;
    logic [63:0] O_bus_wdata;
    logic [7:0]  O_bus_wstrb;
    logic        I_bus_resp_valid;
    logic [63:0] I_bus_rdata;
    logic        O_busy;

    typedef struct packed {
        logic        mem;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    ysyx_22040750_mem_arbiter #(.STARVE_MAX(4)) dut (
        .I_sys_clk        (I_sys_clk),
        .I_rst_n          (I_rst_n),
        .I_if_req_valid   (I_if_req_valid),
        .I_if_addr        (I_if_addr),
        .O_if_req_ready   (O_if_req_ready),
        .O_if_resp_valid  (O_if_resp_valid),
        .O_if_rdata       (O_if_rdata),
        .I_mem_req_valid  (I_mem_req_valid),
        .I_mem_addr       (I_mem_addr),
        .I_mem_wen        (I_mem_wen),
        .I_mem_wdata      (I_mem_wdata),
        .I_mem_wstrb      (I_mem_wstrb),
        .O_mem_req_ready  (O_mem_req_ready),
        .O_mem_resp_valid (O_mem_resp_valid),
        .O_mem_rdata      (O_mem_rdata),
        .O_bus_req_valid  (O_bus_req_valid),
        .I_bus_req_ready  (I_bus_req_ready),
        .O_bus_addr       (O_bus_addr),
        .O_bus_wen        (O_bus_wen),
        .O_bus_wdata      (O_bus_wdata),
        .O_bus_wstrb      (O_bus_wstrb),
        .I_bus_resp_valid (I_bus_resp_valid),
        .I_bus_rdata      (I_bus_rdata),
        .O_busy           (O_busy)
    );

    initial I_sys_clk = 1'b0;
    always #5 I_sys_clk = ~I_sys_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_sys_clk);
        #1;
    endtask

    // one full transaction from an IDLE cycle; expected owner and bus fields come from the caller
    task automatic txn(input logic m, input logic [31:0] addr, input logic wen,
                       input logic [63:0] wdata, input logic [7:0] wstrb,
                       input int rdy_dly, input logic [63:0] rdata, input logic drop);
        exp_t e;
        #1;
        chk("busy_idle", O_busy, 1'b0);
        chk("if_req_ready", O_if_req_ready, !m);
        chk("mem_req_ready", O_mem_req_ready, m);
        tick();
        if (drop) begin
            if (m) I_mem_req_valid = 1'b0;
            else   I_if_req_valid  = 1'b0;
        end
        for (int k = 0; k <= rdy_dly; k++) begin
            #1;
            chk("bus_req_valid", O_bus_req_valid, 1'b1);
            chk("bus_addr", O_bus_addr, addr);
            chk("bus_wen", O_bus_wen, wen);
            chk("bus_wdata", O_bus_wdata, wdata);
            chk("bus_wstrb", O_bus_wstrb, wstrb);
            chk("ready_low_req", {O_if_req_ready, O_mem_req_ready}, 2'b00);
            if (k == rdy_dly) I_bus_req_ready = 1'b1;
            tick();
            I_bus_req_ready = 1'b0;
        end
        #1;
        chk("busy_wait", O_busy, 1'b1);
        chk("bus_valid_wait", O_bus_req_valid, 1'b0);
        I_bus_resp_valid = 1'b1;
        I_bus_rdata      = rdata;
        sb.push_back('{mem: m, data: wen ? 64'h0 : rdata});
        tick();
        I_bus_resp_valid = 1'b0;
        e = sb.pop_front();
        chk("if_resp_valid", O_if_resp_valid, !e.mem);
        chk("mem_resp_valid", O_mem_resp_valid, e.mem);
        chk(e.mem ? "mem_rdata" : "if_rdata", e.mem ? O_mem_rdata : O_if_rdata, e.data);
        chk("busy_done", O_busy, 1'b0);
    endtask

    initial begin
        I_rst_n          = 1'b0;
        I_if_req_valid   = 1'b0;
        I_if_addr        = '0;
        I_mem_req_valid  = 1'b0;
        I_mem_addr       = '0;
        I_mem_wen        = 1'b0;
        I_mem_wdata      = '0;
        I_mem_wstrb      = '0;
        I_bus_req_ready  = 1'b0;
        I_bus_resp_valid = 1'b0;
        I_bus_rdata      = '0;
        #2;
        chk("rst_busy", O_busy, 1'b0);
        chk("rst_bus_valid", O_bus_req_valid, 1'b0);
        chk("rst_outputs", {O_if_resp_valid, O_mem_resp_valid, O_bus_wen, O_bus_addr}, 35'h0);
        repeat (2) tick();
        @(negedge I_sys_clk);
        I_rst_n = 1'b1;
        tick();
        // spurious bus response while idle
        I_bus_resp_valid = 1'b1;
        I_bus_rdata      = 64'hCAFE_F00D_0000_0001;
        tick();
        I_bus_resp_valid = 1'b0;
        chk("spur_resp", {O_if_resp_valid, O_mem_resp_valid}, 2'b00);
        chk("spur_busy", O_busy, 1'b0);
        chk("spur_rdata", O_if_rdata | O_mem_rdata, 64'h0);
        // IF-only fetch at minimum latency
        I_if_req_valid = 1'b1;
        I_if_addr      = 32'h8000_0000;
        txn(1'b0, 32'h8000_0000, 1'b0, 64'h0, 8'h0, 0, 64'h1122_3344_5566_7788, 1'b1);
        tick();
        chk("pulse_once", {O_if_resp_valid, O_mem_resp_valid}, 2'b00);
        // both valid: MEM first, IF next
        I_if_req_valid  = 1'b1;
        I_if_addr       = 32'h8000_0040;
        I_mem_req_valid = 1'b1;
        I_mem_addr      = 32'h8000_3000;
        I_mem_wen       = 1'b0;
        I_mem_wdata     = 64'h0123_4567_89AB_CDEF;
        I_mem_wstrb     = 8'hFF;
        txn(1'b1, 32'h8000_3000, 1'b0, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 64'hAAAA_0000_BBBB_1111, 1'b1);
        txn(1'b0, 32'h8000_0040, 1'b0, 64'h0, 8'h0, 1, 64'h5555_6666_7777_8888, 1'b1);
        // continuous contention: MEM x4 then IF, twice
        I_if_req_valid  = 1'b1;
        I_mem_req_valid = 1'b1;
        I_mem_wdata     = 64'hA5A5_A5A5_5A5A_5A5A;
        for (int i = 0; i < 10; i++) begin
            logic m;
            m = (i % 5) != 4;
            txn(m, m ? 32'h8000_3000 : 32'h8000_0040, 1'b0, m ? 64'hA5A5_A5A5_5A5A_5A5A : 64'h0,
                m ? 8'hFF : 8'h0, 0, 64'h1000 + 64'(i), 1'b0);
        end
        I_if_req_valid  = 1'b0;
        I_mem_req_valid = 1'b0;
        tick();
        // store with bus ready held off for 3 cycles
        I_mem_req_valid = 1'b1;
        I_mem_addr      = 32'h8000_1000;
        I_mem_wen       = 1'b1;
        I_mem_wdata     = 64'hDEAD_BEEF;
        I_mem_wstrb     = 8'h0F;
        txn(1'b1, 32'h8000_1000, 1'b1, 64'hDEAD_BEEF, 8'h0F, 3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        I_mem_wen = 1'b0;
        // reset asserted during WAIT
        I_if_req_valid = 1'b1;
        I_if_addr      = 32'h8000_0080;
        #1;
        chk("rst_case_grant", O_if_req_ready, 1'b1);
        tick();
        I_if_req_valid  = 1'b0;
        I_bus_req_ready = 1'b1;
        tick();
        I_bus_req_ready = 1'b0;
        #2;
        chk("pre_rst_busy", O_busy, 1'b1);
        I_rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", O_busy, 1'b0);
        chk("mid_rst_bus", {O_bus_req_valid, O_bus_wen, O_bus_wstrb, O_bus_addr}, 42'h0);
        chk("mid_rst_rdata", O_if_rdata | O_mem_rdata | O_bus_wdata, 64'h0);
        I_if_req_valid = 1'b1;
        #1;
        chk("mid_rst_ready", O_if_req_ready, 1'b0);
        I_if_req_valid = 1'b0;
        @(negedge I_sys_clk);
        I_rst_n          = 1'b1;
        I_bus_resp_valid = 1'b1;
        I_bus_rdata      = 64'h9999_8888_7777_6666;
        tick();
        I_bus_resp_valid = 1'b0;
        chk("late_resp", {O_if_resp_valid, O_mem_resp_valid}, 2'b00);
        tick();
        chk("late_resp2", {O_if_resp_valid, O_mem_resp_valid}, 2'b00);
        chk("post_rst_busy", O_busy, 1'b0);
        chk("post_rst_rdata", O_if_rdata, 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_22040750_mem_arbiter.md
YSYX_22040750_MEM_ARBITER -- requirements
Module: ysyx_22040750_mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4, meaning consecutive MEM grants allowed while IF waits.
REQ-002 SHALL have port I_sys_clk, input, 1, system clock; all state on its rising edge.
REQ-003 SHALL have port I_rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have IF requester ports:
- I_if_req_valid, input, 1, fetch request.
- I_if_addr, input, 32, fetch address.
- O_if_req_ready, output, 1, request accepted.
- O_if_resp_valid, output, 1, fetch data valid.
- O_if_rdata, output, 64, fetch data.
REQ-005 SHALL have MEM requester ports:
- I_mem_req_valid, input, 1, load/store request.
- I_mem_addr, input, 32, address.
- I_mem_wen, input, 1, write when 1.
- I_mem_wdata, input, 64, write data.
- I_mem_wstrb, input, 8, byte strobes.
- O_mem_req_ready, output, 1, request accepted.
- O_mem_resp_valid, output, 1, response or write ack.
- O_mem_rdata, output, 64, load data.
REQ-006 SHALL have bus ports:
- O_bus_req_valid, output, 1.
- I_bus_req_ready, input, 1.
- O_bus_addr, output, 32.
- O_bus_wen, output, 1.
- O_bus_wdata, output, 64.
- O_bus_wstrb, output, 8.
- I_bus_resp_valid, input, 1.
- I_bus_rdata, input, 64.
REQ-007 SHALL have port O_busy, output, 1, high whenever state is not IDLE.

Function
REQ-008 SHALL implement states IDLE, REQ and WAIT, with one outstanding transaction at a time.
REQ-009 IDLE: with any request valid, SHALL grant one requester, assert its req_ready combinationally that cycle, latch addr/wen/wdata/wstrb and owner, and go to REQ.
REQ-010 Priority: MEM over IF, except IF wins when both are valid and starve_cnt == STARVE_MAX.
REQ-011 starve_cnt:
- increments on a MEM grant while I_if_req_valid is high;
- clears on an IF grant, or on a MEM grant with IF idle;
- saturates at STARVE_MAX.
REQ-012 IF grants SHALL drive bus wen=0, wstrb=0 and wdata=0.
REQ-013 REQ: O_bus_req_valid=1 with latched fields held stable; on I_bus_req_ready SHALL move to WAIT.
REQ-014 WAIT: on I_bus_resp_valid SHALL register I_bus_rdata to the owner's rdata, pulse only the owner's resp_valid the next cycle, and return to IDLE.
REQ-015 On MEM writes, O_mem_rdata SHALL be 0 and O_mem_resp_valid SHALL still pulse as the ack.
REQ-016 SHALL ignore I_bus_resp_valid outside WAIT and I_bus_req_ready outside REQ.
REQ-017 The non-owner resp_valid SHALL be 0; req_ready SHALL be 0 outside IDLE.
REQ-018 Minimum latency (bus ready and response each at first opportunity):
- grant at t;
- bus handshake at t+1;
- response at t+2;
- resp_valid at t+3, which is also the earliest next grant.

Reset
REQ-019 I_rst_n low SHALL immediately force state IDLE, starve_cnt 0, owner IF, and all outputs and latched fields 0.
REQ-020 Reset mid-transaction SHALL drop the transaction with no response pulse; on release the block SHALL resume in IDLE.

Structure
REQ-021 State encoding and owner encoding (IF=0, MEM=1) SHALL live in shared package ysyx_22040750_bus_pkg.
REQ-022 The grant/starvation logic SHALL be sub-module ysyx_22040750_prio_sel; the FSM and datapath stay in the top.

Verification
REQ-023 IF only, addr 0x80000000, bus ready at first REQ cycle, response 0x1122334455667788 one cycle later -> O_if_resp_valid at grant+3 with that data, O_mem_resp_valid 0.
REQ-024 IF and MEM both valid in IDLE -> MEM granted first; IF granted at the next IDLE.
REQ-025 MEM valid continuously, IF valid continuously -> grants MEM,MEM,MEM,MEM,IF, then the pattern repeats.
REQ-026 MEM store, addr 0x80001000, wdata 0xDEADBEEF, wstrb 0x0F, bus ready held low 3 cycles -> bus fields stable over all 3 cycles, then ack with O_mem_rdata 0.
REQ-027 I_rst_n pulsed low during WAIT -> outputs 0 asynchronously; a late I_bus_resp_valid produces no resp pulse; state IDLE.
REQ-028 Spurious I_bus_resp_valid in IDLE -> no response outputs and no state change.
